spi_slave_transmitter: RTL and testbench

- MISO half of the Raspberry Pi SPI link. Mode 0 (CPOL=0, CPHA=0).
- Loads bytes from a valid/ready source into a one-entry holding register, then shifts them out MSB-first on spi_miso while spi_cs_n is low.
- Oversamples SCLK/CS in the 25 MHz system clock domain, as the MOSI receiver does, and sits beside it on the same SPI pins.

---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_slave_transmitter_if.sv | 27 ++
 rtl/spi_sync_edge.sv | 40 ++++
 rtl/spi_slave_transmitter.sv | 154 +++++++++++++++
 tb/tb_spi_slave_transmitter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Purpose: shared word width, idle fill byte, synchroniser depth and FSM state type for the SPI slave blocks.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package spi_pkg;

  localparam int SPI_WORD_W = 8;
  localparam logic [SPI_WORD_W-1:0] SPI_IDLE_BYTE = 8'hFF;
  localparam int SYNC_STAGES = 2;

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

endpackage

// File: rtl/spi_slave_transmitter_if.sv
// Purpose: byte stream into the MISO transmitter plus its status pulses.
// Latency: none (wiring only).
// Backpressure: tx_valid/tx_ready handshake; byte_sent/underrun are one-clk pulses with no backpressure.
// Ports: tx_data, tx_valid (source -> transmitter); tx_ready, byte_sent, underrun (transmitter -> source).
interface spi_slave_transmitter_if
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_WORD_W
);

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              byte_sent;
  logic              underrun;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, byte_sent, underrun
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, byte_sent, underrun
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Purpose: synchronise an asynchronous pin into clk and produce level plus single-cycle rise/fall strobes.
// Latency: pin change shows as a strobe after 2 clk edges, so logic acting on it responds on the 3rd edge.
// Backpressure: none; strobes are lost if nobody consumes them that cycle.
// Ports: clk, reset (sync, active-high), din (async pin), level (synchronised), rise, fall (strobes).
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~dly_q;
  assign fall  = ~level & dly_q;

endmodule

// File: rtl/spi_slave_transmitter.sv
// Purpose: SPI mode-0 MISO transmitter; one-entry holding register feeding an MSB-first shift register.
// Latency: SCLK/CS pin edges act 3 clk edges later; MSB is on spi_miso before the first SCLK rise.
// Backpressure: tx_ready low while the holding register is full; an empty register at load time sends IDLE_BYTE.
// Ports: clk, reset (sync, active-high), spi_sclk/spi_cs_n (async pins), spi_miso/spi_miso_oe (registered pad
//        drive), tx (slave side of the byte stream: tx_data/tx_valid/tx_ready, byte_sent and underrun pulses).
module spi_slave_transmitter
  import spi_pkg::*;
#(
  parameter int                DATA_W    = SPI_WORD_W,
  parameter logic [DATA_W-1:0] IDLE_BYTE = SPI_IDLE_BYTE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    spi_sclk,
  input  logic                    spi_cs_n,
  output logic                    spi_miso,
  output logic                    spi_miso_oe,
  spi_slave_transmitter_if.slave  tx
);

  localparam int CNT_W = $clog2(DATA_W);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall, cs_active;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .reset(reset), .din(spi_sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .reset(reset), .din(spi_cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  assign cs_active = ~cs_lvl;

  // Only the SCLK strobes and the CS level/fall drive the FSM.
  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_lvl, cs_rise};

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              reload_pend_q, reload_pend_d;
  logic              miso_q, miso_d;
  logic              miso_oe_q, miso_oe_d;
  logic              byte_sent_q, byte_sent_d;
  logic              underrun_q, underrun_d;
  logic              load;
  logic              accept;

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    hold_vld_d    = hold_vld_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    reload_pend_d = reload_pend_q;
    miso_oe_d     = miso_oe_q;
    byte_sent_d   = 1'b0;
    underrun_d    = 1'b0;
    load          = 1'b0;
    accept        = tx.tx_valid & ~hold_vld_q;

    case (state_q)
      TX_IDLE: begin
        miso_oe_d = 1'b0;
        if (cs_fall) begin
          load          = 1'b1;
          bit_cnt_d     = '0;
          reload_pend_d = 1'b0;
          miso_oe_d     = 1'b1;
          state_d       = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        // Deselect wins over any SCLK strobe seen in the same cycle, so a
        // trailing fall that coincides with CS rise does not reload.
        if (!cs_active) begin
          state_d       = TX_IDLE;
          miso_oe_d     = 1'b0;
          bit_cnt_d     = '0;
          reload_pend_d = 1'b0;
        end else if (sclk_rise) begin
          if (bit_cnt_q == CNT_W'(DATA_W-1)) begin
            byte_sent_d   = 1'b1;
            bit_cnt_d     = '0;
            reload_pend_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall) begin
          if (reload_pend_q) begin
            load          = 1'b1;
            reload_pend_d = 1'b0;
          end else begin
            shift_d = shift_q << 1;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // The load looks at the holding register as it was before this edge, so
    // a word accepted in the same cycle waits for the next load.
    if (load) begin
      shift_d    = hold_vld_q ? hold_q : IDLE_BYTE;
      underrun_d = ~hold_vld_q;
      hold_vld_d = 1'b0;
    end
    if (accept) begin
      hold_d     = tx.tx_data;
      hold_vld_d = 1'b1;
    end

    miso_d = (state_d == TX_SHIFT) ? shift_d[DATA_W-1] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= TX_IDLE;
      hold_q        <= '0;
      hold_vld_q    <= 1'b0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      reload_pend_q <= 1'b0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      byte_sent_q   <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      hold_vld_q    <= hold_vld_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      reload_pend_q <= reload_pend_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
      byte_sent_q   <= byte_sent_d;
      underrun_q    <= underrun_d;
    end
  end

  assign spi_miso     = miso_q;
  assign spi_miso_oe  = miso_oe_q;
  assign tx.tx_ready  = ~hold_vld_q;
  assign tx.byte_sent = byte_sent_q;
  assign tx.underrun  = underrun_q;

endmodule

// File: tb/tb_spi_slave_transmitter.sv
// Purpose: directed bench for the SPI MISO transmitter acting as a mode-0 master (SCLK = clk/10).
// Latency: outputs are sampled on clk falling edges, inputs driven on falling edges or just after rising edges.
// Backpressure: the byte source waits on tx_ready with a bounded cycle budget.
module tb_spi_slave_transmitter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic spi_sclk = 1'b0;
  logic spi_cs_n = 1'b1;
  logic spi_miso;
  logic spi_miso_oe;

  int total = 0;
  int bad = 0;
  int bs_cnt = 0;
  int ur_cnt = 0;
  int rdy_low = 0;

  spi_slave_transmitter_if #(.DATA_W(8)) tx_if ();

  spi_slave_transmitter dut (
    .clk(clk),
    .reset(reset),
    .spi_sclk(spi_sclk),
    .spi_cs_n(spi_cs_n),
    .spi_miso(spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .tx(tx_if)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_if.byte_sent === 1'b1) bs_cnt++;
    if (tx_if.underrun === 1'b1) ur_cnt++;
    if (tx_if.tx_ready === 1'b0) rdy_low++;
  end

  task automatic clear_counts();
    bs_cnt = 0;
    ur_cnt = 0;
    rdy_low = 0;
  endtask

  task automatic push(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    tx_if.tx_data = b;
    tx_if.tx_valid = 1'b1;
    while (tx_if.tx_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (tx_if.tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL push_wait byte=%h tx_ready=%b required=1", b, tx_if.tx_ready);
    end
    @(posedge clk);
    #1 tx_if.tx_valid = 1'b0;
  endtask

  // Called on a clk falling edge; samples MISO as SCLK rises.
  task automatic sclk_bit(output logic b, input bit end_cs);
    b = spi_miso;
    spi_sclk = 1'b1;
    repeat (5) @(negedge clk);
    spi_sclk = 1'b0;
    if (end_cs) spi_cs_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic frame(input int nbits, output logic [15:0] rx);
    logic b;
    rx = '0;
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sclk_bit(b, i == nbits - 1);
      rx = {rx[14:0], b};
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total += 5;
    if (spi_miso !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b exp=0", spi_miso); end
    if (spi_miso_oe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b exp=0", spi_miso_oe); end
    if (tx_if.tx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", tx_if.tx_ready); end
    if (tx_if.byte_sent !== 1'b0) begin bad++; $display("FAIL reset_byte_sent got=%b exp=0", tx_if.byte_sent); end
    if (tx_if.underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b exp=0", tx_if.underrun); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    logic [15:0] rx;
    push(8'hA5);
    clear_counts();
    frame(8, rx);
    total += 4;
    if (rx !== 16'h00A5) begin bad++; $display("FAIL single_data got=%h exp=00a5", rx); end
    if (bs_cnt !== 1) begin bad++; $display("FAIL single_byte_sent got=%0d exp=1", bs_cnt); end
    if (ur_cnt !== 0) begin bad++; $display("FAIL single_underrun got=%0d exp=0", ur_cnt); end
    if (spi_miso_oe !== 1'b0) begin bad++; $display("FAIL single_oe_after got=%b exp=0", spi_miso_oe); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rx;
    push(8'h3C);
    clear_counts();
    fork
      frame(16, rx);
      push(8'hC3);
    join
    total += 3;
    if (rx !== 16'h3CC3) begin bad++; $display("FAIL b2b_data got=%h exp=3cc3", rx); end
    if (bs_cnt !== 2) begin bad++; $display("FAIL b2b_byte_sent got=%0d exp=2", bs_cnt); end
    if (ur_cnt !== 0) begin bad++; $display("FAIL b2b_underrun got=%0d exp=0", ur_cnt); end
  endtask

  task automatic test_underrun();
    logic [15:0] rx;
    clear_counts();
    frame(8, rx);
    total += 4;
    if (rx !== 16'h00FF) begin bad++; $display("FAIL underrun_data got=%h exp=00ff", rx); end
    if (ur_cnt !== 1) begin bad++; $display("FAIL underrun_pulses got=%0d exp=1", ur_cnt); end
    if (rdy_low !== 0) begin bad++; $display("FAIL underrun_ready_low_cycles got=%0d exp=0", rdy_low); end
    if (bs_cnt !== 1) begin bad++; $display("FAIL underrun_byte_sent got=%0d exp=1", bs_cnt); end
  endtask

  task automatic test_abort();
    logic [15:0] rx;
    logic b;
    logic [2:0] part;
    part = '0;
    push(8'hF0);
    clear_counts();
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sclk_bit(b, 1'b0);
      part = {part[1:0], b};
    end
    spi_cs_n = 1'b1;
    repeat (2) @(negedge clk);
    total += 4;
    if (part !== 3'b111) begin bad++; $display("FAIL abort_partial got=%b exp=111", part); end
    if (spi_miso_oe !== 1'b1) begin bad++; $display("FAIL abort_oe_2clk got=%b exp=1", spi_miso_oe); end
    @(negedge clk);
    if (spi_miso_oe !== 1'b0) begin bad++; $display("FAIL abort_oe_3clk got=%b exp=0", spi_miso_oe); end
    repeat (3) @(negedge clk);
    if (bs_cnt !== 0) begin bad++; $display("FAIL abort_byte_sent got=%0d exp=0", bs_cnt); end
    push(8'h81);
    clear_counts();
    frame(8, rx);
    total += 2;
    if (rx !== 16'h0081) begin bad++; $display("FAIL abort_next_data got=%h exp=0081", rx); end
    if (bs_cnt !== 1) begin bad++; $display("FAIL abort_next_byte_sent got=%0d exp=1", bs_cnt); end
  endtask

  task automatic test_hold_full();
    logic [15:0] rx;
    int n;
    push(8'h11);
    @(negedge clk);
    tx_if.tx_data = 8'h22;
    tx_if.tx_valid = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (tx_if.tx_ready !== 1'b0) begin bad++; $display("FAIL hold_full_ready got=%b exp=0", tx_if.tx_ready); end
    clear_counts();
    n = 0;
    fork
      frame(16, rx);
      begin
        while (tx_if.tx_ready !== 1'b1 && n < 100) begin
          @(negedge clk);
          n++;
        end
        total++;
        if (tx_if.tx_ready !== 1'b1) begin bad++; $display("FAIL hold_full_accept tx_ready=%b exp=1", tx_if.tx_ready); end
        @(posedge clk);
        #1 tx_if.tx_valid = 1'b0;
      end
    join
    total += 3;
    if (rx !== 16'h1122) begin bad++; $display("FAIL hold_full_data got=%h exp=1122", rx); end
    if (bs_cnt !== 2) begin bad++; $display("FAIL hold_full_byte_sent got=%0d exp=2", bs_cnt); end
    if (ur_cnt !== 0) begin bad++; $display("FAIL hold_full_underrun got=%0d exp=0", ur_cnt); end
  endtask

  task automatic test_reset_mid_word();
    logic [15:0] rx;
    logic b;
    push(8'h5A);
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (6) @(negedge clk);
    push(8'h77);
    @(negedge clk);
    total++;
    if (tx_if.tx_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_hold_full got=%b exp=0", tx_if.tx_ready); end
    sclk_bit(b, 1'b0);
    sclk_bit(b, 1'b0);
    reset = 1'b1;
    spi_cs_n = 1'b1;
    clear_counts();
    @(negedge clk);
    total += 3;
    if (spi_miso_oe !== 1'b0) begin bad++; $display("FAIL rst_mid_oe got=%b exp=0", spi_miso_oe); end
    if (tx_if.tx_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b exp=1", tx_if.tx_ready); end
    if (spi_miso !== 1'b0) begin bad++; $display("FAIL rst_mid_miso got=%b exp=0", spi_miso); end
    repeat (2) @(negedge clk);
    total++;
    if (bs_cnt + ur_cnt !== 0) begin bad++; $display("FAIL rst_mid_pulses got=%0d exp=0", bs_cnt + ur_cnt); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    clear_counts();
    frame(8, rx);
    total += 2;
    if (rx !== 16'h00FF) begin bad++; $display("FAIL rst_mid_next_data got=%h exp=00ff", rx); end
    if (ur_cnt !== 1) begin bad++; $display("FAIL rst_mid_next_underrun got=%0d exp=1", ur_cnt); end
  endtask

  initial begin
    tx_if.tx_data = '0;
    tx_if.tx_valid = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_hold_full();
    test_reset_mid_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
